mem_access_unit: RTL and testbench

//   Initiator for the word-wide, big-endian data memory port. Accepts load/store

---
 rtl/mem_access_unit.sv | 176 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-wide, big-endian data memory port.
// Sub-word stores are done as read-modify-write; bad accesses answer with an error only.
module mem_access_unit #(
  parameter logic [31:0] START = 32'h10008000,
  parameter int unsigned BYTES = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_word;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic [1:0]  w_nm1;
  logic [32:0] w_last;
  logic        w_lo_ok;
  logic        w_hi_ok;
  logic        w_misalign;
  logic        w_req_err;
  logic [4:0]  w_bsh;
  logic [4:0]  w_hsh;
  logic [31:0] w_bsrc;
  logic [31:0] w_hsrc;
  logic [31:0] w_merged;
  logic [31:0] w_load;

  // Handshakes: a request transfers on a posedge where req_valid && req_ready;
  // a response transfers on a posedge where resp_valid && resp_ready. Response
  // fields never change while resp_valid is high and unacknowledged.
  assign w_accept = req_valid && (r_state == IDLE);

  // Window check uses the address of the last byte touched by the access.
  always_comb begin
    w_nm1 = 2'd0;
    case (req_size)
      2'b01:   w_nm1 = 2'd1;
      2'b11:   w_nm1 = 2'd3;
      default: w_nm1 = 2'd0;
    endcase
  end

  assign w_last     = {1'b0, req_addr} + {31'd0, w_nm1};
  assign w_lo_ok    = (req_addr >= START);
  assign w_hi_ok    = (w_last <= ({1'b0, START} + 33'(BYTES) - 33'd1));
  assign w_misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b11) && (req_addr[1:0] != 2'b00));
  assign w_req_err  = (req_size == 2'b10) || w_misalign || !w_lo_ok || !w_hi_ok;

  // Big-endian lanes: byte offset 0 sits in [31:24], half offset 0 in [31:16].
  assign w_bsh  = {~r_addr[1:0], 3'b000};
  assign w_hsh  = r_addr[1] ? 5'd0 : 5'd16;
  assign w_bsrc = mem_rdata >> w_bsh;
  assign w_hsrc = mem_rdata >> w_hsh;

  always_comb begin
    w_merged = r_wdata;
    w_load   = mem_rdata;
    case (r_size)
      2'b00: begin
        w_merged = (mem_rdata & ~(32'h000000FF << w_bsh)) |
                   ({24'd0, r_wdata[7:0]} << w_bsh);
        w_load   = r_unsigned ? {24'd0, w_bsrc[7:0]} : {{24{w_bsrc[7]}}, w_bsrc[7:0]};
      end
      2'b01: begin
        w_merged = (mem_rdata & ~(32'h0000FFFF << w_hsh)) |
                   ({16'd0, r_wdata[15:0]} << w_hsh);
        w_load   = r_unsigned ? {16'd0, w_hsrc[15:0]} : {{16{w_hsrc[15]}}, w_hsrc[15:0]};
      end
      default: begin
        w_merged = r_wdata;
        w_load   = mem_rdata;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_req_err)              w_next = RESP;
          else if (!req_we)           w_next = RD;
          else if (req_size == 2'b11) w_next = WR;
          else                        w_next = RD;
        end
      end
      RD:      w_next = r_we ? WR : RESP;
      WR:      w_next = RESP;
      RESP:    if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // r_word always holds the word that WR will write, so mem_wdata stays a pure register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_word     <= 32'd0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_rdata    <= 32'd0;
            r_err      <= w_req_err;
            if (req_we && (req_size == 2'b11) && !w_req_err) r_word <= req_wdata;
          end
        end
        RD: begin
          if (r_we) r_word  <= w_merged;
          else      r_rdata <= w_load;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign mem_read   = (r_state == RD);
  assign mem_write  = (r_state == WR);
  assign mem_addr   = {r_addr[31:2], 2'b00};
  assign mem_wdata  = r_word;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed spec cases, randomized traffic against a
// byte-level memory model, backpressure, back-to-back and reset during a write.
module tb_mem_access_unit;

  localparam logic [31:0] START   = 32'h10008000;
  localparam int          BYTES   = 1024;
  localparam longint      START_L = 64'h10008000;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  int checks;
  int errors;
  int cyc;
  int proto_bad;

  logic [31:0] exp_q[$];
  logic [7:0]  ref_bytes [0:1023];
  logic [31:0] env_mem [0:255];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_data;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  mem_access_unit #(.START(START), .BYTES(BYTES)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / environment ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic in_win(logic [31:0] a);
    return (a - START) < 32'(BYTES);
  endfunction

  always @(posedge clk) begin
    if (pre_we) env_mem[pre_idx] <= pre_data;
    else if (mem_write && in_win(mem_addr)) env_mem[8'((mem_addr - START) >> 2)] <= mem_wdata;
  end

  always_comb begin
    mem_rdata = 32'h0;
    if (mem_read && in_win(mem_addr)) mem_rdata = env_mem[8'((mem_addr - START) >> 2)];
  end

  always @(negedge clk) begin
    if (rstn && ((mem_read && mem_write) ||
                 ((resp_valid || req_ready) && (mem_read || mem_write)) ||
                 ((mem_read || mem_write) && !in_win(mem_addr))))
      proto_bad <= proto_bad + 1;
  end

  // ---------------- reference model ----------------
  task automatic ref_access(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int lat,
                            output int nrd, output int nwr, output logic [31:0] wword);
    int n;
    int off;
    int base;
    longint a;
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    a = {32'd0, addr};
    rdata = 32'd0; wword = 32'd0; nrd = 0; nwr = 0; lat = 1;
    err = (size == 2'b10) || (a % n != 0) || (a < START_L) || (a + n > START_L + BYTES);
    if (err) return;
    off = int'(a - START_L);
    if (!we) begin
      for (int i = 0; i < n; i++) rdata = (rdata << 8) | {24'd0, ref_bytes[off + i]};
      if (!uns && n < 4 && rdata[8*n-1]) rdata = rdata | (32'hFFFFFFFF << (8*n));
      lat = 2; nrd = 1;
    end else begin
      for (int i = 0; i < n; i++) ref_bytes[off + i] = 8'(wdata >> (8*(n-1-i)));
      base  = off - (off % 4);
      wword = {ref_bytes[base], ref_bytes[base+1], ref_bytes[base+2], ref_bytes[base+3]};
      nwr = 1; nrd = (n < 4) ? 1 : 0; lat = (n < 4) ? 3 : 2;
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int nrd, output int nwr, output logic [31:0] wword,
                         output logic addr_ok);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1; nrd = 0; nwr = 0; wword = 32'd0; addr_ok = 1'b1;
    @(negedge clk);
    while (!resp_valid && lat < 10) begin
      if (mem_read) nrd++;
      if (mem_write) begin nwr++; wword = mem_wdata; end
      if ((mem_read || mem_write) && (mem_addr !== {addr[31:2], 2'b00})) addr_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) lat = 99;
    rdata = resp_rdata;
    err   = resp_err;
    @(posedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1; pre_we = 1'b0;
    pre_idx = 8'd0; pre_data = 32'd0;
    for (int w = 0; w < 256; w++) begin
      @(negedge clk);
      d = (w == 0) ? 32'h8899AABB : $urandom();
      pre_we = 1'b1; pre_idx = 8'(w); pre_data = d;
      ref_bytes[4*w] = d[31:24]; ref_bytes[4*w+1] = d[23:16];
      ref_bytes[4*w+2] = d[15:8]; ref_bytes[4*w+3] = d[7:0];
    end
    @(negedge clk);
    pre_we = 1'b0;
    checks++;
    if ({req_ready, resp_valid, resp_err, mem_read, mem_write} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 10000", {req_ready, resp_valid, resp_err, mem_read, mem_write});
    end
    checks++;
    if ({resp_rdata, mem_addr, mem_wdata} !== 96'd0) begin
      errors++;
      $display("FAIL reset_data rdata %h addr %h wdata %h exp all 0", resp_rdata, mem_addr, mem_wdata);
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL post_reset ready/valid got %b exp 10", {req_ready, resp_valid});
    end
  endtask

  task automatic test_directed();
    req_t tbl [14];
    logic [31:0] spec_rd [7];
    logic [31:0] erd, rd, eww, ww;
    logic eerr, err, aok;
    int elat, enrd, enwr, lat, nrd, nwr;
    tbl[0]  = '{1'b0, 2'b00, 1'b0, 32'h10008000, 32'h0};
    tbl[1]  = '{1'b0, 2'b00, 1'b1, 32'h10008000, 32'h0};
    tbl[2]  = '{1'b0, 2'b01, 1'b0, 32'h10008002, 32'h0};
    tbl[3]  = '{1'b0, 2'b01, 1'b1, 32'h10008002, 32'h0};
    tbl[4]  = '{1'b0, 2'b11, 1'b0, 32'h10008000, 32'h0};
    tbl[5]  = '{1'b1, 2'b00, 1'b0, 32'h10008001, 32'h00000011};
    tbl[6]  = '{1'b0, 2'b11, 1'b0, 32'h10008000, 32'h0};
    tbl[7]  = '{1'b0, 2'b11, 1'b0, 32'h10008002, 32'h0};
    tbl[8]  = '{1'b1, 2'b01, 1'b0, 32'h10008003, 32'h1234};
    tbl[9]  = '{1'b0, 2'b11, 1'b0, 32'h10008400, 32'h0};
    tbl[10] = '{1'b1, 2'b00, 1'b0, 32'h10008400, 32'h55};
    tbl[11] = '{1'b0, 2'b10, 1'b0, 32'h10008000, 32'h0};
    tbl[12] = '{1'b1, 2'b11, 1'b0, 32'h100083FC, 32'hCAFEF00D};
    tbl[13] = '{1'b0, 2'b01, 1'b0, 32'h10007FFE, 32'h0};
    spec_rd[0] = 32'hFFFFFF88; spec_rd[1] = 32'h00000088; spec_rd[2] = 32'hFFFFAABB;
    spec_rd[3] = 32'h0000AABB; spec_rd[4] = 32'h8899AABB; spec_rd[5] = 32'h0;
    spec_rd[6] = 32'h8811AABB;
    for (int i = 0; i < 14; i++) begin
      ref_access(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
                 erd, eerr, elat, enrd, enwr, eww);
      run_txn(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
              rd, err, lat, nrd, nwr, ww, aok);
      checks++;
      if (rd !== erd) begin errors++; $display("FAIL dir[%0d] rdata got %h exp %h", i, rd, erd); end
      checks++;
      if (err !== eerr) begin errors++; $display("FAIL dir[%0d] err got %b exp %b", i, err, eerr); end
      checks++;
      if (lat != elat) begin errors++; $display("FAIL dir[%0d] latency got %0d exp %0d", i, lat, elat); end
      checks++;
      if (nrd != enrd || nwr != enwr) begin
        errors++; $display("FAIL dir[%0d] rd/wr cycles got %0d/%0d exp %0d/%0d", i, nrd, nwr, enrd, enwr);
      end
      checks++;
      if (!aok) begin errors++; $display("FAIL dir[%0d] mem_addr not word address of %h", i, tbl[i].addr); end
      if (enwr == 1) begin
        checks++;
        if (ww !== eww) begin errors++; $display("FAIL dir[%0d] mem_wdata got %h exp %h", i, ww, eww); end
      end
      if (i < 7) begin
        checks++;
        if (rd !== spec_rd[i]) begin errors++; $display("FAIL dir_spec[%0d] rdata got %h exp %h", i, rd, spec_rd[i]); end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] addr, wdata, erd, rd, eww, ww;
    logic [1:0] size;
    logic we, uns, eerr, err, aok;
    int m, s, elat, enrd, enwr, lat, nrd, nwr;
    for (int i = 0; i < 150; i++) begin
      m = $urandom_range(0, 9);
      if (m == 0)      addr = START + 32'(BYTES) + $urandom_range(0, 7);
      else if (m == 1) addr = START - 32'd1 - $urandom_range(0, 7);
      else             addr = START + $urandom_range(0, BYTES - 1);
      if (m >= 4) addr[0] = 1'b0;
      if (m >= 6) addr[1:0] = 2'b00;
      s = $urandom_range(0, 9);
      size = (s < 3) ? 2'b00 : (s < 6) ? 2'b01 : (s < 9) ? 2'b11 : 2'b10;
      we = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      wdata = $urandom();
      ref_access(we, size, uns, addr, wdata, erd, eerr, elat, enrd, enwr, eww);
      exp_q.push_back(erd);
      run_txn(we, size, uns, addr, wdata, rd, err, lat, nrd, nwr, ww, aok);
      erd = exp_q.pop_front();
      checks++;
      if (rd !== erd) begin errors++; $display("FAIL rnd[%0d] rdata @%h got %h exp %h", i, addr, rd, erd); end
      checks++;
      if (err !== eerr) begin errors++; $display("FAIL rnd[%0d] err @%h got %b exp %b", i, addr, err, eerr); end
      checks++;
      if (lat != elat) begin errors++; $display("FAIL rnd[%0d] latency got %0d exp %0d", i, lat, elat); end
      checks++;
      if (nrd != enrd || nwr != enwr || !aok) begin
        errors++; $display("FAIL rnd[%0d] mem access got rd %0d wr %0d addr_ok %b exp rd %0d wr %0d",
                           i, nrd, nwr, aok, enrd, enwr);
      end
      if (enwr == 1) begin
        checks++;
        if (ww !== eww) begin errors++; $display("FAIL rnd[%0d] mem_wdata got %h exp %h", i, ww, eww); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] erd1, erd2, eww;
    logic eerr;
    int elat, enrd, enwr, guard;
    ref_access(1'b0, 2'b11, 1'b0, START + 32'd8, 32'd0, erd1, eerr, elat, enrd, enwr, eww);
    ref_access(1'b0, 2'b11, 1'b0, START + 32'd12, 32'd0, erd2, eerr, elat, enrd, enwr, eww);
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b11; req_unsigned = 1'b0; req_addr = START + 32'd8;
    @(posedge clk);
    #1 req_valid = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!resp_valid && guard < 10) begin @(negedge clk); guard++; end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({resp_valid, req_ready} !== 2'b10 || resp_rdata !== erd1) begin
        errors++;
        $display("FAIL hold[%0d] valid/ready %b rdata %h exp 10 %h", k, {resp_valid, req_ready}, resp_rdata, erd1);
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    req_valid = 1'b1; req_addr = START + 32'd12;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      errors++; $display("FAIL after_handshake ready/valid got %b exp 10", {req_ready, resp_valid});
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_read !== 1'b1 || mem_addr !== START + 32'd12) begin
      errors++; $display("FAIL next_accept mem_read %b addr %h exp 1 %h", mem_read, mem_addr, START + 32'd12);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== erd2) begin
      errors++; $display("FAIL next_resp valid %b rdata %h exp 1 %h", resp_valid, resp_rdata, erd2);
    end
    @(posedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr, erd, rd, eww, ww;
    logic eerr, err, aok;
    int elat, enrd, enwr, lat, nrd, nwr, c0, c1;
    c0 = 0;
    for (int i = 0; i < 4; i++) begin
      addr = START + ($urandom_range(0, 255) << 2);
      ref_access(1'b0, 2'b11, 1'b0, addr, 32'd0, erd, eerr, elat, enrd, enwr, eww);
      exp_q.push_back(erd);
      run_txn(1'b0, 2'b11, 1'b0, addr, 32'd0, rd, err, lat, nrd, nwr, ww, aok);
      #1;
      if (i == 0) c0 = cyc;
      erd = exp_q.pop_front();
      checks++;
      if (rd !== erd || err !== 1'b0) begin
        errors++; $display("FAIL b2b[%0d] rdata %h err %b exp %h 0", i, rd, err, erd);
      end
    end
    c1 = cyc;
    checks++;
    if (c1 - c0 != 9) begin errors++; $display("FAIL b2b_cycles got %0d exp 9", c1 - c0); end
  endtask

  task automatic test_reset_mid_wr();
    logic [31:0] erd, rd, eww, ww;
    logic eerr, err, aok;
    int elat, enrd, enwr, lat, nrd, nwr;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = START + 32'd21; req_wdata = 32'h0000005A ^ {24'd0, ref_bytes[21]};
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_write !== 1'b1) begin errors++; $display("FAIL mid_wr mem_write got %b exp 1", mem_write); end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_err, mem_read, mem_write} !== 5'b10000 ||
        {resp_rdata, mem_addr, mem_wdata} !== 96'd0) begin
      errors++;
      $display("FAIL async_reset ctrl %b rdata %h addr %h wdata %h exp 10000 and zeros",
               {req_ready, resp_valid, resp_err, mem_read, mem_write}, resp_rdata, mem_addr, mem_wdata);
    end
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    ref_access(1'b0, 2'b11, 1'b0, START + 32'd20, 32'd0, erd, eerr, elat, enrd, enwr, eww);
    run_txn(1'b0, 2'b11, 1'b0, START + 32'd20, 32'd0, rd, err, lat, nrd, nwr, ww, aok);
    checks++;
    if (rd !== erd || err !== 1'b0) begin
      errors++; $display("FAIL abandoned_rmw word got %h err %b exp %h 0", rd, err, erd);
    end
  endtask

  task automatic test_final_memory();
    int bad;
    bad = 0;
    for (int w = 0; w < 256; w++)
      if (env_mem[w] !== {ref_bytes[4*w], ref_bytes[4*w+1], ref_bytes[4*w+2], ref_bytes[4*w+3]}) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL memory_image got %0d differing words exp 0", bad); end
    checks++;
    if (proto_bad != 0) begin errors++; $display("FAIL protocol got %0d bad cycles exp 0", proto_bad); end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; proto_bad = 0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_wr();
    test_final_memory();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
